// File: rtl/output_port_driver.sv
// CPU-writable output port: registered pins with per-bit blink and stretched pulse modes,
// plus a registered read-back path. All outputs come straight from flops.
module output_port_driver #(
    parameter int WIDTH        = 8,
    parameter int BLINK_DIV    = 12_500_000,
    parameter int PULSE_CYCLES = 5_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] pins,
    output logic             blink_phase
);

    localparam int PRE_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int CNT_W = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_BLINK  = 2'd1,
        REG_TOGGLE = 2'd2,
        REG_PULSE  = 2'd3
    } reg_sel_t;

    reg_sel_t         sel;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] blink_mask;
    logic [WIDTH-1:0] pulse_mask;
    logic [CNT_W-1:0] pulse_cnt;
    logic [PRE_W-1:0] prescaler;
    logic [WIDTH-1:0] pin_next;
    logic [WIDTH-1:0] read_mux;
    logic             pulse_wr;

    assign sel      = reg_sel_t'(addr);
    assign pulse_wr = wr_en && (sel == REG_PULSE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_reg   <= '0;
            blink_mask <= '0;
        end else if (wr_en) begin
            case (sel)
                REG_DATA:   data_reg   <= wdata;
                REG_BLINK:  blink_mask <= wdata;
                REG_TOGGLE: data_reg   <= data_reg ^ wdata;
                default:    ;
            endcase
        end
    end

    // A PULSE write on the expiry edge takes priority, so the mask never drops for a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse_mask <= '0;
            pulse_cnt  <= '0;
        end else if (pulse_wr) begin
            pulse_mask <= pulse_mask | wdata;
            pulse_cnt  <= CNT_RELOAD;
        end else if (pulse_mask != '0) begin
            if (pulse_cnt != '0)
                pulse_cnt <= pulse_cnt - 1'b1;
            else
                pulse_mask <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            blink_phase <= 1'b0;
        end else if (prescaler == PRE_MAX) begin
            prescaler   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        pin_next = (data_reg & (~blink_mask | {WIDTH{blink_phase}})) | pulse_mask;
    end

    always_comb begin
        read_mux = '0;
        case (sel)
            REG_DATA:   read_mux = data_reg;
            REG_BLINK:  read_mux = blink_mask;
            REG_TOGGLE: read_mux = WIDTH'(blink_phase);
            REG_PULSE:  read_mux = pulse_mask;
            default:    read_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pins  <= '0;
            rdata <= '0;
        end else begin
            pins <= pin_next;
            if (rd_en)
                rdata <= read_mux;
        end
    end

endmodule

// File: tb/tb_output_port_driver.sv
// Directed self-checking bench for output_port_driver (WIDTH=8, BLINK_DIV=4, PULSE_CYCLES=5).
module tb_output_port_driver;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] pins;
    logic       blink_phase;

    int n_checks = 0;
    int n_fail   = 0;

    output_port_driver #(
        .WIDTH(8),
        .BLINK_DIV(4),
        .PULSE_CYCLES(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .pins(pins),
        .blink_phase(blink_phase)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge, where inputs are driven and outputs sampled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        #1;

        // Test 1: reset state, DATA write latency, read-back
        reset = 1'b1;
        #1;
        check("rst_pins", pins, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_phase", 8'(blink_phase), 8'h00);
        do_reset();
        wr(2'd0, 8'hA5);
        check("t1_pins_edge_n", pins, 8'h00);
        rd(2'd0);
        check("t1_pins_edge_n1", pins, 8'hA5);
        check("t1_rdata", rdata, 8'hA5);

        // Test 2: blink on low nibble, first phase toggle at edge 4 after release
        do_reset();
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'h0F);
        for (int k = 3; k <= 12; k++) begin
            if (k == 5) begin
                rd_en = 1'b1;
                addr  = 2'd2;
            end
            tick();
            rd_en = 1'b0;
            check($sformatf("t2_pins_k%0d", k), pins, ((((k - 1) / 4) % 2) == 1) ? 8'hFF : 8'hF0);
            check($sformatf("t2_phase_k%0d", k), 8'(blink_phase), 8'((k / 4) % 2));
            if (k == 5)
                check("t2_rd_phase", rdata, 8'h01);
        end
        rd(2'd1);
        check("t2_rd_blink", rdata, 8'h0F);

        // Test 3: single pulse lasts 5 cycles; second pulse extends both bits
        do_reset();
        wr(2'd3, 8'h01);
        check("t3_pins_k1", pins, 8'h00);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check($sformatf("t3_pins_k%0d", k), pins, (k <= 6) ? 8'h01 : 8'h00);
        end
        wr(2'd3, 8'h01);
        check("t3_pins_k9", pins, 8'h00);
        tick();
        check("t3_pins_k10", pins, 8'h01);
        wr(2'd3, 8'h02);
        check("t3_pins_k11", pins, 8'h01);
        for (int k = 12; k <= 17; k++) begin
            tick();
            check($sformatf("t3_pins_k%0d", k), pins, (k <= 16) ? 8'h03 : 8'h00);
        end

        // Test 4: PULSE write on the expiry edge, with same-address read
        wr(2'd3, 8'h04);
        check("t4_pins_e0", pins, 8'h00);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check($sformatf("t4_pins_e%0d", j), pins, 8'h04);
        end
        rd_en = 1'b1;
        wr(2'd3, 8'h08);
        rd_en = 1'b0;
        check("t4_pins_e5", pins, 8'h04);
        check("t4_rd_prewrite", rdata, 8'h04);
        rd(2'd3);
        check("t4_pins_e6", pins, 8'h0C);
        check("t4_rd_reload", rdata, 8'h0C);
        for (int j = 7; j <= 11; j++) begin
            tick();
            check($sformatf("t4_pins_e%0d", j), pins, (j <= 10) ? 8'h0C : 8'h00);
        end

        // Test 5: TOGGLE twice from 0x3C
        do_reset();
        wr(2'd0, 8'h3C);
        wr(2'd2, 8'h0F);
        check("t5_pins_lag1", pins, 8'h3C);
        rd(2'd0);
        check("t5_rd_33", rdata, 8'h33);
        check("t5_pins_33", pins, 8'h33);
        wr(2'd2, 8'h0F);
        check("t5_pins_lag2", pins, 8'h33);
        rd(2'd0);
        check("t5_rd_3c", rdata, 8'h3C);
        check("t5_pins_3c", pins, 8'h3C);

        // Test 6: async reset mid-pulse and mid-blink, then blink restarts from zero
        do_reset();
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'h0F);
        wr(2'd3, 8'hFF);
        rd(2'd0);
        check("t6_rd_pre", rdata, 8'hFF);
        tick();
        tick();
        check("t6_pins_pre", pins, 8'hFF);
        check("t6_phase_pre", 8'(blink_phase), 8'h01);
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_pins", pins, 8'h00);
        check("t6_async_rdata", rdata, 8'h00);
        check("t6_async_phase", 8'(blink_phase), 8'h00);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("t6_phase_k%0d", k), 8'(blink_phase), (k >= 4) ? 8'h01 : 8'h00);
            check($sformatf("t6_pins_k%0d", k), pins, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_port_driver.md
Name: output_port_driver

Overview:
- Output-side counterpart of the input synchronizer: the CPU core writes output-port registers through a simple one-cycle write strobe.
- The block drives the board LEDs/pins from registered flip-flops only, so pins are glitch-free.
- Per-bit blink mode (shared prescaler) and a stretched one-shot pulse mode let short CPU events stay visible on LEDs.
- A registered read-back path lets software read the port state.

Parameters:
WIDTH, 8, number of output pins / register width.
BLINK_DIV, 12_500_000, clock cycles per blink phase (50 MHz -> 2 Hz blink).
PULSE_CYCLES, 5_000_000, clock cycles a pulse-mode bit is held high (100 ms at 50 MHz).

Ports:
clock  in  1  50 MHz system clock.
reset  in  1  reset, asynchronous and active-high (one clock, all flops async-cleared).
wr_en  in  1  write strobe, sampled each rising edge; one write per high cycle.
rd_en  in  1  read strobe, sampled each rising edge.
addr  in  2  register select for read/write.
wdata  in  WIDTH  write data.
rdata  out  WIDTH  read data, registered.
pins  out  WIDTH  registered output pins.
blink_phase  out  1  current blink phase (for CPU sync/debug).

Behaviour:
- Reset (async, immediate): data_reg, blink_mask, pulse_mask, prescaler, pulse_cnt, blink_phase, rdata and pins all 0. Reset mid-operation aborts pulses and blink timing instantly; no output glitch beyond forcing 0.
- Register map on write (wr_en=1 at edge):
  - addr 0 DATA: data_reg <= wdata.
  - addr 1 BLINK: blink_mask <= wdata.
  - addr 2 TOGGLE: data_reg <= data_reg ^ wdata.
  - addr 3 PULSE: pulse_mask <= pulse_mask | wdata; pulse_cnt <= PULSE_CYCLES-1. Retriggers/extends on every write, including wdata=0 while a pulse is active.
- Pulse counter:
  - While pulse_mask != 0 and pulse_cnt != 0, pulse_cnt decrements each cycle.
  - On the edge where pulse_cnt == 0 and pulse_mask != 0, pulse_mask <= 0.
  - A PULSE write on that same edge wins: OR/reload is applied and the clear is skipped.
  - Each pulsed bit is therefore high in pulse_mask for exactly PULSE_CYCLES cycles after the last PULSE write.
- Blink prescaler:
  - Free-running counter 0..BLINK_DIV-1; wraps to 0 at BLINK_DIV-1, and blink_phase toggles on that wrap edge.
  - First toggle (0->1) occurs BLINK_DIV cycles after reset release. The prescaler is never reset by register writes.
- Pin function per bit i (computed from the register values, then registered):
  - pins[i] <= (blink_mask[i] ? (data_reg[i] & blink_phase) : data_reg[i]) | pulse_mask[i].
  - Pulse overrides blink and data.
  - Latency: a write at edge N updates the register at edge N; pins reflect it at edge N+1.
- Read (rd_en=1 at edge N): rdata valid after edge N, holds until the next read.
  - addr 0 -> data_reg; addr 1 -> blink_mask; addr 2 -> {WIDTH{0}} except bit 0 = blink_phase; addr 3 -> pulse_mask.
  - Read values are the pre-write values if a write to the same address happens at the same edge.
- Simultaneous wr_en and rd_en are both honoured.
- WIDTH-wide registers only; counters sized $clog2 of their maxima (min 1 bit). BLINK_DIV and PULSE_CYCLES >= 2 required.

Test Plan:
(Parameters WIDTH=8, BLINK_DIV=4, PULSE_CYCLES=5 for the bench.)
1. Reset then write DATA=0xA5 at edge N -> pins=0x00 through edge N, pins=0xA5 after edge N+1; read addr0 -> rdata=0xA5.
2. DATA=0xFF, BLINK=0x0F -> pins alternate 0xF0/0xFF every 4 cycles; blink_phase toggles every 4 cycles, first 0->1 at cycle 4 after reset.
3. DATA=0x00, PULSE write 0x01 -> pins[0] high for exactly 5 cycles (delayed 1 cycle), then 0. A second PULSE 0x02 written at cycle 3 of the first pulse -> bits 0 and 1 stay high until 5 cycles after the second write.
4. PULSE write on the exact expiry edge -> no low gap on pins; pulse_mask reloaded.
5. TOGGLE 0x0F twice from DATA=0x3C -> data_reg 0x33 then 0x3C; pins follow with 1-cycle lag.
6. Assert reset mid-pulse and mid-blink with pins=0xFF -> pins, rdata and blink_phase 0 immediately (asynchronously, before the next edge); after release, blink restarts with the full BLINK_DIV period.
